// File: rtl/ifft_frame_scheduler.sv
// Round-robin frame scheduler feeding one shared IFFT core from two channels.
// Tags each frame on entry so the emerging output frame can be attributed.
module ifft_frame_scheduler #(
    parameter int FFT_LEN   = 1024,
    parameter int CNT_W     = 10,
    parameter int DW        = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [DW-1:0]    a_real,
    input  logic [DW-1:0]    a_imag,
    input  logic [DW-1:0]    b_real,
    input  logic [DW-1:0]    b_imag,
    output logic             rd_a,
    output logic             rd_b,
    input  logic             core_ready,
    output logic             sink_valid,
    output logic             sink_sop,
    output logic             sink_eop,
    output logic [DW-1:0]    sink_real,
    output logic [DW-1:0]    sink_imag,
    input  logic             src_valid,
    input  logic             src_sop,
    input  logic             src_eop,
    input  logic [1:0]       src_error,
    output logic             out_chan,
    output logic             out_valid,
    output logic [CNT_W-1:0] fft_in_cnt,
    output logic [CNT_W-1:0] fft_out_cnt,
    output logic             busy,
    output logic             err
);

    localparam int TAG_W = $clog2(TAG_DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FFT_LEN - 1);
    localparam logic [TAG_W:0] TAG_FULL = (TAG_W + 1)'(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, GRANT, STREAM, GAP} state_t;

    state_t state, state_nxt;

    logic grant, pick, sel, rr, rd;
    logic push, pop, tag_full, tag_empty;
    logic sop_seen, err_now;
    logic [TAG_W-1:0] wr_ptr, rd_ptr;
    logic [TAG_W:0] tag_cnt;
    logic [TAG_DEPTH-1:0] tags;

    assign tag_full  = (tag_cnt == TAG_FULL);
    assign tag_empty = (tag_cnt == '0);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pick      = rr;
        unique case (state)
            IDLE: begin
                if ((req_a | req_b) && !tag_full) begin
                    grant     = 1'b1;
                    pick      = (req_a && req_b) ? rr : req_b;
                    state_nxt = GRANT;
                end
            end
            GRANT:  state_nxt = STREAM;
            STREAM: if (rd && fft_in_cnt == LAST) state_nxt = GAP;
            GAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd   = (state == STREAM) && core_ready;
    assign rd_a = rd && !sel;
    assign rd_b = rd && sel;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            rr         <= 1'b0;
            fft_in_cnt <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            sink_real  <= '0;
            sink_imag  <= '0;
        end else begin
            state      <= state_nxt;
            sink_valid <= rd;
            sink_sop   <= rd && (fft_in_cnt == '0);
            sink_eop   <= rd && (fft_in_cnt == LAST);
            if (grant) begin
                sel <= pick;
                rr  <= ~pick;
            end
            if (state == GRANT) fft_in_cnt <= '0;
            else if (rd) fft_in_cnt <= fft_in_cnt + 1'b1;
            if (rd) begin
                sink_real <= sel ? b_real : a_real;
                sink_imag <= sel ? b_imag : a_imag;
            end
        end
    end

    // Tag FIFO: one entry per frame granted but not yet out of the core
    assign push = grant;
    assign pop  = src_valid && src_eop && !tag_empty;

    assign out_valid = src_valid && !tag_empty;
    assign out_chan  = !tag_empty && tags[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tags    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= pick;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // A misplaced sop is only meaningful once a first frame has framed the count
    assign err_now = src_valid && ((src_error != 2'b00) || tag_empty ||
                     (src_sop && sop_seen && fft_out_cnt != LAST));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fft_out_cnt <= '0;
            sop_seen    <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (src_valid) begin
                fft_out_cnt <= src_sop ? '0 : fft_out_cnt + 1'b1;
                if (src_sop) sop_seen <= 1'b1;
            end
            if (err_now) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifft_frame_scheduler.sv
// Directed bench for ifft_frame_scheduler: grant order, framing, stalls,
// tag FIFO back-pressure, sticky errors and mid-frame reset.
module tb_ifft_frame_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_a, req_b;
    logic [7:0] a_real, a_imag, b_real, b_imag;
    logic       rd_a, rd_b;
    logic       core_ready;
    logic       sink_valid, sink_sop, sink_eop;
    logic [7:0] sink_real, sink_imag;
    logic       src_valid, src_sop, src_eop;
    logic [1:0] src_error;
    logic       out_chan, out_valid;
    logic [9:0] fft_in_cnt, fft_out_cnt;
    logic       busy, err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [15:0] pa = 16'h0;
    logic [15:0] pb = 16'h0;

    typedef struct {
        logic ra;
        logic rb;
        logic stl;
        logic ch;
        logic gap;
    } frame_vec_t;

    frame_vec_t tv[4];

    ifft_frame_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .req_b(req_b),
        .a_real(a_real), .a_imag(a_imag),
        .b_real(b_real), .b_imag(b_imag),
        .rd_a(rd_a), .rd_b(rd_b),
        .core_ready(core_ready),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_error(src_error),
        .out_chan(out_chan), .out_valid(out_valid),
        .fft_in_cnt(fft_in_cnt), .fft_out_cnt(fft_out_cnt),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Show-ahead sample sources: a new distinct sample after every pop
    assign a_real = pa[7:0];
    assign a_imag = pa[15:8] ^ 8'h5a;
    assign b_real = pb[7:0] ^ 8'hc3;
    assign b_imag = pb[15:8];

    always @(posedge clk) begin
        if (rd_a) pa <= pa + 16'd1;
        if (rd_b) pb <= pb + 16'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    int last_eop_cyc = 0;

    task automatic run_frame(input logic ra, input logic rb, input logic stl,
                             input logic exp_ch, input logic gap);
        int got = 0, issued = 0, stall_n = 0, gapn = 0, n = 0;
        int bad_sop = 0, bad_eop = 0, bad_dat = 0, wrong = 0;
        int sop_c = 0, eop_c = 0;
        logic ch = 1'b0;
        logic [15:0] q[$];
        logic [15:0] e;
        req_a = ra;
        req_b = rb;
        core_ready = 1'b1;
        while (n < 1300) begin
            tick();
            n++;
            if (sink_valid) begin
                if (q.size() == 0) begin
                    bad_dat++;
                end else begin
                    e = q.pop_front();
                    if ({sink_real, sink_imag} !== e) bad_dat++;
                end
                if (sink_sop !== (got == 0)) bad_sop++;
                if (sink_eop !== (got == 1023)) bad_eop++;
                if (got == 0) sop_c = cyc;
                if (got == 1023) eop_c = cyc;
                got++;
            end else if (got == 500) begin
                gapn++;
            end
            if (got == 1024) break;
            core_ready = !(stl && issued == 500 && stall_n < 5);
            if (!core_ready) stall_n++;
            #1;
            if (rd_a || rd_b) begin
                if (!core_ready || (rd_a && rd_b)) wrong++;
                if (issued == 0) ch = rd_b;
                else if (rd_b !== ch) wrong++;
                q.push_back(rd_b ? {b_real, b_imag} : {a_real, a_imag});
                issued++;
            end
        end
        core_ready = 1'b1;
        check("frame_len", got, 1024);
        check("frame_rd_cnt", issued, 1024);
        check("frame_chan", int'(ch), int'(exp_ch));
        check("frame_sop", bad_sop, 0);
        check("frame_eop", bad_eop, 0);
        check("frame_data", bad_dat, 0);
        check("frame_bad_rd", wrong, 0);
        check("frame_stall_gap", gapn, stl ? 5 : 0);
        if (gap) check("frame_b2b_gap", sop_c - last_eop_cyc, 4);
        last_eop_cyc = eop_c;
    endtask

    task automatic out_frame(input logic exp_ch);
        int bad_v = 0, bad_c = 0;
        for (int k = 0; k < 1024; k++) begin
            src_valid = 1'b1;
            src_sop = (k == 0);
            src_eop = (k == 1023);
            #1;
            if (out_valid !== 1'b1) bad_v++;
            if (out_chan !== exp_ch) bad_c++;
            tick();
        end
        src_valid = 1'b0;
        src_sop = 1'b0;
        src_eop = 1'b0;
        check("out_valid", bad_v, 0);
        check("out_chan", bad_c, 0);
        check("out_cnt_end", int'(fft_out_cnt), 1023);
    endtask

    initial begin
        int hits, issued;
        tv[0] = '{ra: 1'b1, rb: 1'b0, stl: 1'b0, ch: 1'b0, gap: 1'b0};
        tv[1] = '{ra: 1'b1, rb: 1'b1, stl: 1'b0, ch: 1'b1, gap: 1'b1};
        tv[2] = '{ra: 1'b1, rb: 1'b1, stl: 1'b1, ch: 1'b0, gap: 1'b1};
        tv[3] = '{ra: 1'b1, rb: 1'b1, stl: 1'b0, ch: 1'b1, gap: 1'b1};

        reset_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        core_ready = 1'b0;
        src_valid = 1'b0;
        src_sop = 1'b0;
        src_eop = 1'b0;
        src_error = 2'b00;
        repeat (3) tick();
        check("rst_outputs",
              int'({rd_a, rd_b, sink_valid, sink_sop, sink_eop, busy,
                    err, out_valid, out_chan}), 0);
        check("rst_sink_data", int'({sink_real, sink_imag}), 0);
        check("rst_in_cnt", int'(fft_in_cnt), 0);
        check("rst_out_cnt", int'(fft_out_cnt), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_frame(tv[i].ra, tv[i].rb, tv[i].stl, tv[i].ch, tv[i].gap);

        // Tag FIFO now full: no grant until the core emits an eop
        req_a = 1'b1;
        req_b = 1'b0;
        hits = 0;
        repeat (20) begin
            tick();
            if (busy || rd_a || rd_b) hits++;
        end
        check("full_blocks_grant", hits, 0);
        out_frame(1'b0);
        check("full_still_idle", int'(busy), 0);
        tick();
        check("grant_after_pop", int'(busy), 1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        req_a = 1'b0;

        out_frame(1'b1);
        out_frame(1'b0);
        out_frame(1'b1);
        out_frame(1'b0);
        check("no_err_clean_run", int'(err), 0);

        // Output with an empty tag FIFO
        src_valid = 1'b1;
        #1;
        check("empty_out_valid", int'(out_valid), 0);
        tick();
        src_valid = 1'b0;
        check("err_empty", int'(err), 1);
        repeat (5) tick();
        check("err_sticky", int'(err), 1);

        reset_n = 1'b0;
        repeat (2) tick();
        check("err_cleared", int'(err), 0);
        reset_n = 1'b1;
        run_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        req_b = 1'b0;
        src_valid = 1'b1;
        src_sop = 1'b1;
        src_error = 2'b01;
        #1;
        check("errcode_out_valid", int'(out_valid), 1);
        check("errcode_out_chan", int'(out_chan), 1);
        tick();
        src_valid = 1'b0;
        src_sop = 1'b0;
        src_error = 2'b00;
        check("err_code", int'(err), 1);

        // Abandon a frame mid-stream with reset
        req_a = 1'b1;
        core_ready = 1'b1;
        issued = 0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (issued == 300) break;
            #1;
            if (rd_a) issued++;
        end
        check("mid_in_cnt", int'(fft_in_cnt), 300);
        reset_n = 1'b0;
        tick();
        check("mid_rst_outputs",
              int'({rd_a, rd_b, sink_valid, sink_sop, sink_eop, busy, err}), 0);
        check("mid_rst_in_cnt", int'(fft_in_cnt), 0);
        src_valid = 1'b1;
        #1;
        check("mid_rst_tags_empty", int'({out_valid, out_chan}), 0);
        src_valid = 1'b0;
        reset_n = 1'b1;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        req_a = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
